// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that holds the MIPS HI/LO registers.
// It runs MULT/MULTU as XLEN shift-add steps and DIV/DIVU as XLEN restoring
// shift-subtract steps on magnitudes. A final FIX cycle applies the result signs.
// MTHI/MTLO write HI/LO in a single cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   start    in   request strobe, accepted only while idle
//   op       in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                 110/111 no-op
//   rs_data  in   dividend / multiplicand / MTHI-MTLO source
//   rt_data  in   divisor / multiplier
//   busy     out  high while a multiply/divide is in flight (registered)
//   done     out  one-cycle pulse when HI/LO take a multiply/divide result
//   hi, lo   out  architectural HI/LO registers
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int         W2   = 2 * XLEN;
    localparam logic [5:0] LAST = 6'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [W2-1:0]     acc_q, acc_d;
    // opa holds the multiplicand magnitude or the divisor magnitude
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   rs_q, rs_d;
    logic              is_div_q, is_div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              dz_q, dz_d;

    logic signed [XLEN-1:0] rs_s, rt_s;
    logic              is_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [W2-1:0]     prod;
    logic [XLEN-1:0]   quo, rem;

    assign rs_s = rs_data;
    assign rt_s = rt_data;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [W2-1:0] cond_neg_wide(input logic [W2-1:0] v, input logic n);
        return n ? (~v + W2'(1)) : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        rs_d      = rs_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        dz_d      = dz_q;
        prod      = '0;
        quo       = '0;
        rem       = '0;

        // MULT and DIV have op[0]=0; only those take operand signs into account
        is_signed = ~op[0];
        a_neg     = is_signed && (rs_s < 0);
        b_neg     = is_signed && (rt_s < 0);
        a_mag     = cond_neg(rs_data, a_neg);
        b_mag     = cond_neg(rt_data, b_neg);

        mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opa_q};
        // {remainder, next dividend bit} minus divisor; MSB set means it does not fit
        div_trial = {acc_q[W2-1:XLEN], acc_q[XLEN-1]} - {1'b0, opa_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        state_d  = CALC;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        dz_d     = op[1] && (rt_data == '0);
                        rs_d     = rs_data;
                        if (op[1]) begin
                            opa_d = b_mag;
                            acc_d = {{XLEN{1'b0}}, a_mag};
                        end else begin
                            opa_d = a_mag;
                            acc_d = {{XLEN{1'b0}}, b_mag};
                        end
                    end else if (op[1:0] == 2'b00) begin
                        hi_d = rs_data;
                    end else if (op[1:0] == 2'b01) begin
                        lo_d = rs_data;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!div_trial[XLEN]) begin
                        acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[W2-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    quo = cond_neg(acc_q[XLEN-1:0], neg_lo_q);
                    rem = cond_neg(acc_q[W2-1:XLEN], neg_hi_q);
                    if (dz_q) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    prod = cond_neg_wide(acc_q, neg_lo_q);
                    hi_d = prod[W2-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and architectural state: cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Working datapath: always reloaded at acceptance, so no reset needed
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        opa_q    <= opa_d;
        rs_q     <= rs_d;
        is_div_q <= is_div_d;
        neg_lo_q <= neg_lo_d;
        neg_hi_q <= neg_hi_d;
        dz_q     <= dz_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] sb[$];
    int          n_cmp;
    int          n_err;
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [63:0] last_exp;

    // Reference: {hi,lo} from plain integer arithmetic on the architectural operands
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ia, ib, q, r;
        logic [63:0] p;
        ia = longint'($signed(a));
        ib = longint'($signed(b));
        p  = '0;
        case (o)
            3'd0: p = 64'(ia * ib);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0)                                p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else begin
                    q = ia / ib;
                    r = ia % ib;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    e = sb.pop_front();
                    if ({hi, lo} !== e) begin
                        n_err++;
                        $display("FAIL result: got %h expected %h", {hi, lo}, e);
                    end
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge following the acceptance edge
    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        if (o <= 3'd3) begin
            last_exp = model(o, a, b);
            sb.push_back(last_exp);
        end else if (o == 3'd4) begin
            hi_m = a;
        end else if (o == 3'd5) begin
            lo_m = a;
        end
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 16) chk({name, "_hold"}, {hi, lo}, {hi_m, lo_m});
        end
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_low"}, 64'(busy), 64'd0);
        hi_m = last_exp[63:32];
        lo_m = last_exp[31:0];
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        drive(o, a, b);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        wait_done(name, 33);
    endtask

    initial begin
        bit seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        n_cmp   = 0;
        n_err   = 0;
        hi_m    = '0;
        lo_m    = '0;
        last_exp = '0;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_data = '0;
        rt_data = '0;
        fork
            monitor();
        join_none

        @(negedge clk);
        chk("reset_state", {32'(busy), 32'(done)}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
        do_op("multu_neg", 3'd1, 32'hFFFF_FFFD, 32'd7);
        do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op("divu", 3'd3, 32'd100, 32'd7);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_zero", 3'd3, 32'h1234_5678, 32'd0);
        do_op("div_zero_neg", 3'd2, 32'hF000_0001, 32'd0);

        drive(3'd4, 32'hDEAD_BEEF, 32'd0);
        chk("mthi", {hi, lo}, {hi_m, lo_m});
        chk("mthi_ctrl", {32'(busy), 32'(done)}, 64'd0);
        drive(3'd5, 32'hCAFE_F00D, 32'd0);
        chk("mtlo", {hi, lo}, {hi_m, lo_m});
        drive(3'd6, 32'h1111_1111, 32'd0);
        chk("noop_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("noop_hilo", {hi, lo}, {hi_m, lo_m});

        // MTLO and a second MULT issued while busy must both be ignored
        drive(3'd0, 32'h0001_0003, 32'hFFFF_FF00);
        repeat (4) @(negedge clk);
        op = 3'd5; rs_data = 32'h55AA_55AA; start = 1'b1;
        @(negedge clk);
        op = 3'd1; rs_data = 32'd9; rt_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("sneak_busy", 64'(busy), 64'd1);
        wait_done("sneak", 27);

        // A request made in the done cycle is accepted
        drive(3'd1, 32'd6, 32'd7);
        lat_wait: begin
            int n;
            n = 0;
            while (!done && n < 40) begin @(negedge clk); n++; end
            chk("chain_first_lat", 64'(n), 64'd33);
        end
        hi_m = last_exp[63:32];
        lo_m = last_exp[31:0];
        drive(3'd3, 32'd1000, 32'd9);
        chk("chain_accept_busy", 64'(busy), 64'd1);
        wait_done("chain_second", 33);

        // Reset in the middle of a DIV abandons it with no done pulse
        drive(3'd2, 32'hFFFF_FF9C, 32'd3);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("midreset_ctrl", {32'(busy), 32'(done)}, 64'd0);
        sb.delete();
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no_done_after_reset", 64'(seen), 64'd0);
        do_op("multu_after_reset", 3'd1, 32'd3, 32'd5);

        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op("random", ro, ra, rb);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits directly downstream of the general-purpose register file: it takes the rs and rt read-port values and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes HI/LO to the MFHI/MFLO datapath, and its busy flag lets the controller stall dependent instructions.

## Interface
- XLEN, 32, operand width; iteration count equals XLEN.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request strobe; sampled on the rising edge, honoured only when busy=0.
- op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- rs_data  in  XLEN  rs operand (dividend / multiplicand / MTHI-MTLO source).
- rt_data  in  XLEN  rt operand (divisor / multiplier).
- busy  out  1  high while a multiply/divide is in progress.
- done  out  1  one-cycle pulse when HI/LO receive a multiply/divide result.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

## Operation
- States: IDLE, CALC, FIX. busy = (state != IDLE), driven from a register, not decoded from start.
- IDLE, start=1, op=MTHI: hi <= rs_data at that edge; stays IDLE; busy and done stay 0.
- IDLE, start=1, op=MTLO: same behaviour, writing lo.
- IDLE, start=1, op in {110,111}: ignored; no state change.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU: latch operand magnitudes, result signs, op class and a zero-divisor flag. Clear the 6-bit counter. Go to CALC.
  - Signed ops (MULT, DIV) use the two's-complement magnitude of negative operands.
  - Unsigned ops use the operands as-is.
- CALC, multiply: one shift-add step per cycle on a 2*XLEN accumulator.
- CALC, divide: one restoring shift-subtract step per cycle; quotient and remainder are XLEN each.
- CALC -> FIX after exactly XLEN iterations (counter reaches XLEN-1).
- FIX: apply sign correction, write HI/LO, pulse done, return to IDLE.
- Multiply result: {hi,lo} = 2*XLEN-bit product. For MULT, negate the product iff sign(rs) XOR sign(rt).
- DIV / DIVU result: lo = quotient, hi = remainder.
  - DIV quotient sign = sign(rs) XOR sign(rt).
  - DIV remainder sign = sign(rs).
- Divide by zero (rt_data = 0, DIV or DIVU): full latency still applies; hi = rs_data as latched, lo = all ones.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0. This is the natural result of the magnitude arithmetic; no trap.
- Operands are latched at acceptance. rs_data/rt_data may change freely while busy.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The controller must stall.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset asserted mid-operation: the computation is abandoned immediately. All of the above values apply asynchronously, and no done pulse follows.
- Acceptance edge E0: busy=1 from E0.
- Iterations occur on edges E1..E32 (XLEN=32); the FSM enters FIX after E32.
- Edge E33: hi/lo updated, busy=0, done=1. done falls at E34 unless a new operation completes then, which is impossible.
- Latency is XLEN+1 cycles from acceptance to valid HI/LO. Throughput is one op per XLEN+1 cycles. start held continuously restarts on the E33 edge... no: at E33 the state is FIX, so a request is next accepted at E34 (first IDLE edge).
- start=1 in the done cycle is accepted (state is IDLE).
- MTHI/MTLO: single-cycle; value is visible on hi/lo after the sampling edge.
- hi/lo hold their values while busy and show the previous results until E33.

## Test plan
- Reset then MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles; at E33 hi=0xFFFFFFFE, lo=0x00000001, done pulses for exactly 1 cycle.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU of the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 0x12345678 / 0 -> after 33 cycles hi=0x12345678, lo=0xFFFFFFFF, done=1.
- MTHI 0xDEADBEEF -> hi updates at the sampling edge with busy=0, done=0. Issue MTLO while a MULT is busy -> it is ignored; lo takes the MULT result at E33.
- Assert reset at cycle 10 of a DIV -> hi=lo=0, busy=0 immediately; no done pulse afterwards. A new MULTU 3 x 5 then completes with lo=15, hi=0.
